// File: rtl/div_pkg.sv
// Shared definitions for the div_n sequential restoring divider:
// FSM state encoding, counter sizing and the divide-by-zero quotient.
package div_pkg;

  // Divider control states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_FINISH = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Widest operand the all-ones quotient constant below can cover.
  localparam int MAX_WIDTH = 64;

  // Quotient reported on divide-by-zero; sliced down to WIDTH by the user.
  localparam logic [MAX_WIDTH-1:0] DBZ_QUOTIENT = {MAX_WIDTH{1'b1}};

  // Bits needed to hold the step counter value WIDTH down to 0.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift {R,Q} left by one,
// try to subtract B from the partial remainder, and keep the difference
// only when it is non-negative.
module div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0]   r_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH:0]   r_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH+1:0] shifted_s;
  logic [WIDTH+1:0] trial_s;
  logic             trial_ok_s;

  // Shift in the next dividend bit, form the trial difference and restore on borrow.
  always_comb begin
    shifted_s  = {r_i, q_i[WIDTH-1]};
    // One bit wider than the remainder so the top bit is a clean borrow flag.
    trial_s    = shifted_s - {2'b00, b_i};
    trial_ok_s = ~trial_s[WIDTH+1];
    if (trial_ok_s) begin
      r_o = trial_s[WIDTH:0];
    end else begin
      r_o = shifted_s[WIDTH:0];
    end
    q_o = {q_i[WIDTH-2:0], trial_ok_s};
  end

endmodule

// File: rtl/div_n.sv
// div_n: parametrised sequential restoring divider (WIDTH steps per
// operation) with start/done handshake, busy and divide-by-zero flag.
// Optional build macro DIV_SIGNED_EN: operands are two's complement,
// magnitudes are divided and signs are applied in FINISH (truncation
// toward zero). Without it the divider is purely unsigned.
module div_n #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init_in,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] Remainder,
  output logic             done,
  output logic             busy,
  output logic             div_zero
);

  import div_pkg::*;

  localparam int CNT_W = cnt_width(WIDTH);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]     r_q, r_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               dbz_q, dbz_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               div_zero_q, div_zero_d;

  logic [WIDTH:0]     step_r_s;
  logic [WIDTH-1:0]   step_q_s;
  logic [WIDTH-1:0]   fin_quot_s;
  logic [WIDTH-1:0]   fin_rem_s;

`ifdef DIV_SIGNED_EN
  logic               sa_q, sa_d;
  logic               sb_q, sb_d;

  // Two's complement negation at operand width (MIN maps to itself).
  function automatic logic [WIDTH-1:0] twos_neg(input logic [WIDTH-1:0] v);
    return ~v + WIDTH'(1);
  endfunction
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .r_i (r_q),
    .q_i (q_q),
    .b_i (b_q),
    .r_o (step_r_s),
    .q_o (step_q_s)
  );

`ifdef DIV_SIGNED_EN
  // Final quotient/remainder with signs restored; negating the stored
  // dividend magnitude reproduces the original A for divide-by-zero.
  always_comb begin
    if (dbz_q) begin
      fin_quot_s = DBZ_QUOTIENT[WIDTH-1:0];
      fin_rem_s  = sa_q ? twos_neg(q_q) : q_q;
    end else begin
      fin_quot_s = (sa_q ^ sb_q) ? twos_neg(q_q) : q_q;
      fin_rem_s  = sa_q ? twos_neg(r_q[WIDTH-1:0]) : r_q[WIDTH-1:0];
    end
  end
`else
  // Final quotient/remainder; on divide-by-zero Q still holds the untouched dividend.
  always_comb begin
    if (dbz_q) begin
      fin_quot_s = DBZ_QUOTIENT[WIDTH-1:0];
      fin_rem_s  = q_q;
    end else begin
      fin_quot_s = q_q;
      fin_rem_s  = r_q[WIDTH-1:0];
    end
  end
`endif

  // Next-state and datapath update for the IDLE/SHIFT/FINISH/DONE sequence.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    r_d        = r_q;
    q_d        = q_q;
    b_d        = b_q;
    dbz_d      = dbz_q;
    result_d   = result_q;
    rem_d      = rem_q;
    done_d     = 1'b0;
    busy_d     = busy_q;
    div_zero_d = div_zero_q;
`ifdef DIV_SIGNED_EN
    sa_d       = sa_q;
    sb_d       = sb_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (init_in) begin
`ifdef DIV_SIGNED_EN
          sa_d = A[WIDTH-1];
          sb_d = B[WIDTH-1];
          q_d  = A[WIDTH-1] ? twos_neg(A) : A;
          b_d  = B[WIDTH-1] ? twos_neg(B) : B;
`else
          q_d  = A;
          b_d  = B;
`endif
          r_d    = '0;
          cnt_d  = CNT_W'(WIDTH);
          busy_d = 1'b1;
          if (B == '0) begin
            dbz_d   = 1'b1;
            state_d = ST_FINISH;
          end else begin
            dbz_d   = 1'b0;
            state_d = ST_SHIFT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        r_d   = step_r_s;
        q_d   = step_q_s;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_FINISH;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_FINISH: begin
        result_d   = fin_quot_s;
        rem_d      = fin_rem_s;
        div_zero_d = dbz_q;
        busy_d     = 1'b0;
        done_d     = 1'b1;
        state_d    = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and result registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      r_q        <= '0;
      q_q        <= '0;
      b_q        <= '0;
      dbz_q      <= 1'b0;
      result_q   <= '0;
      rem_q      <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      div_zero_q <= 1'b0;
`ifdef DIV_SIGNED_EN
      sa_q       <= 1'b0;
      sb_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      r_q        <= r_d;
      q_q        <= q_d;
      b_q        <= b_d;
      dbz_q      <= dbz_d;
      result_q   <= result_d;
      rem_q      <= rem_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      div_zero_q <= div_zero_d;
`ifdef DIV_SIGNED_EN
      sa_q       <= sa_d;
      sb_q       <= sb_d;
`endif
    end
  end

  assign Result    = result_q;
  assign Remainder = rem_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign div_zero  = div_zero_q;

endmodule
